// File: rtl/logic_exec_pipe_pkg.sv
// Shared constants for the logical execute pipe: opcode encodings and default data width.
// Used by logic_exec_pipe, logic_exec_pipe_if and logic_op_core; no build options live here.
package logic_exec_pipe_pkg;

  localparam int LEP_WIDTH = 24;

  localparam logic [1:0] LOP_AND   = 2'b00;
  localparam logic [1:0] LOP_OR    = 2'b01;
  localparam logic [1:0] LOP_XOR   = 2'b10;
  localparam logic [1:0] LOP_PASSB = 2'b11;

endpackage

// File: rtl/logic_exec_pipe_if.sv
// Handshake bundle for logic_exec_pipe: operand side, result side and flush.
// Build option LOGIC_ZERO_FLAG_EN adds the out_zero result flag.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1;
// the sender keeps valid and its payload stable until that edge, and ready may
// depend combinationally on state but never on the same side's valid.
interface logic_exec_pipe_if
  import logic_exec_pipe_pkg::*;
#(
  parameter int WIDTH = LEP_WIDTH
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_a;
  logic [0:WIDTH-1] in_b;
  logic [1:0]       in_op;
  logic             in_neg;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_y;
`ifdef LOGIC_ZERO_FLAG_EN
  logic             out_zero;
`endif

  modport master (
    output flush, in_valid, in_a, in_b, in_op, in_neg, out_ready,
    input  in_ready, out_valid, out_y
`ifdef LOGIC_ZERO_FLAG_EN
    , input out_zero
`endif
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, in_neg, out_ready,
    output in_ready, out_valid, out_y
`ifdef LOGIC_ZERO_FLAG_EN
    , output out_zero
`endif
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational logic core: AND/OR/XOR/pass-B per bit, optionally complemented.
module logic_op_core
  import logic_exec_pipe_pkg::*;
#(
  parameter int WIDTH = LEP_WIDTH
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [1:0]       op,
  input  logic             neg,
  output logic [0:WIDTH-1] y
);

  logic [0:WIDTH-1] raw;

  always_comb begin
    raw = '0;
    case (op)
      LOP_AND:   raw = a & b;
      LOP_OR:    raw = a | b;
      LOP_XOR:   raw = a ^ b;
      LOP_PASSB: raw = b;
      default:   raw = b;
    endcase
    y = raw ^ {WIDTH{neg}};
  end

endmodule

// File: rtl/logic_exec_pipe.sv
// Two-stage logical execute unit: s1 holds the accepted op, s2 holds the result.
// Build option LOGIC_ZERO_FLAG_EN registers out_zero alongside out_y.
module logic_exec_pipe
  import logic_exec_pipe_pkg::*;
#(
  parameter int WIDTH = LEP_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_exec_pipe_if.slave   bus
);

  logic             s1_valid;
  logic [0:WIDTH-1] s1_a;
  logic [0:WIDTH-1] s1_b;
  logic [1:0]       s1_op;
  logic             s1_neg;

  logic             out_valid_q;
  logic [0:WIDTH-1] out_y_q;
  logic [0:WIDTH-1] core_y;

  logic s2_free;
  logic s1_adv;
  logic in_ready;
  logic accept;

  assign s2_free  = !out_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !bus.flush && (!s1_valid || s2_free);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

  // Stage 1: a new accept wins over draining, which gives back-to-back throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= LOP_AND;
      s1_neg   <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_op    <= bus.in_op;
      s1_neg   <= bus.in_neg;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a   (s1_a),
    .b   (s1_b),
    .op  (s1_op),
    .neg (s1_neg),
    .y   (core_y)
  );

  // Stage 2: result data only moves on s1_adv, so it is frozen during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      out_y_q     <= core_y;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  logic out_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero_q <= 1'b0;
    end else if (!bus.flush && s1_adv) begin
      out_zero_q <= (core_y == '0);
    end
  end

  assign bus.out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_logic_exec_pipe.sv
// Directed plus short random bench for logic_exec_pipe with an expected-result queue.
// Covers the out_zero flag when built with LOGIC_ZERO_FLAG_EN.
module tb_logic_exec_pipe;
  import logic_exec_pipe_pkg::*;

  localparam int WIDTH = LEP_WIDTH;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [WIDTH:0] exp_q[$];

  logic_exec_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_exec_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op, input logic neg);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = b;
    endcase
    return neg ? ~r : r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic neg);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_neg   = neg;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      step();
      n++;
    end
    check(tag, {31'd0, (n < 50)}, 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: the values seen here are what the next rising edge transfers.
  always @(negedge clk) begin
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] y;
    if (rst_n) begin
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("sb_out_y", 32'(bus.out_y), 32'(e[WIDTH-1:0]));
`ifdef LOGIC_ZERO_FLAG_EN
            check("sb_out_zero", {31'd0, bus.out_zero}, {31'd0, e[WIDTH]});
`endif
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          y = model(bus.in_a, bus.in_b, bus.in_op, bus.in_neg);
          exp_q.push_back({(y == '0), y});
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive_op(24'hABCDEF, 24'h123456, LOP_OR, 1'b0);

    // Reset held with in_valid=1
    step(); step(); step();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_y", 32'(bus.out_y), 32'h000000);
`ifdef LOGIC_ZERO_FLAG_EN
    check("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
`endif
    idle();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // XOR stream back-to-back, with latency checks
    drive_op(24'hF010FF, 24'h000000, LOP_XOR, 1'b0);
    step();
    check("lat_s1_only", {31'd0, bus.out_valid}, 32'd0);
    drive_op(24'hF010FF, 24'hFFFFFF, LOP_XOR, 1'b0);
    step();
    check("xor0_valid", {31'd0, bus.out_valid}, 32'd1);
    check("xor0_y", 32'(bus.out_y), 32'hF010FF);
    drive_op(24'hF010FF, 24'hFFF000, LOP_XOR, 1'b0);
    step();
    check("xor1_y", 32'(bus.out_y), 32'h0FEF00);
    idle();
    step();
    check("xor2_y", 32'(bus.out_y), 32'h0FE0FF);
    step();
    check("xor_drained", {31'd0, bus.out_valid}, 32'd0);

    // AND / OR / XNOR / NOT B
    drive_op(24'hF010FF, 24'hFFF000, LOP_AND, 1'b0);
    step();
    drive_op(24'hF010FF, 24'hFFF000, LOP_OR, 1'b0);
    step();
    check("and_y", 32'(bus.out_y), 32'hF01000);
    drive_op(24'hF010FF, 24'hFFF000, LOP_XOR, 1'b1);
    step();
    check("or_y", 32'(bus.out_y), 32'hFFF0FF);
    drive_op(24'hF010FF, 24'hFFF000, LOP_PASSB, 1'b1);
    step();
    check("xnor_y", 32'(bus.out_y), 32'hF01F00);
    idle();
    step();
    check("notb_y", 32'(bus.out_y), 32'h000FFF);
    wait_drain("drain_logic");

    // Backpressure: 3 ops offered with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    drive_op(24'hF010FF, 24'hFFF000, LOP_AND, 1'b0);
    step();
    drive_op(24'hF010FF, 24'hFFF000, LOP_OR, 1'b0);
    check("bp_ready_1", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive_op(24'hF010FF, 24'hFFF000, LOP_XOR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_y", 32'(bus.out_y), 32'hF01000);
      step();
    end
    check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    idle();
    check("bp_second_y", 32'(bus.out_y), 32'hFFF0FF);
    wait_drain("drain_bp");

    // Flush with both stages full and a new op offered
    bus.out_ready = 1'b0;
    drive_op(24'h111111, 24'h222222, LOP_OR, 1'b0);
    step();
    drive_op(24'h333333, 24'h444444, LOP_OR, 1'b0);
    step();
    drive_op(24'h555555, 24'h666666, LOP_OR, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.flush = 1'b0;
    idle();
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("flush_s1_killed", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("flush_no_accept", {31'd0, bus.out_valid}, 32'd0);

    // Zero flag cases
    drive_op(24'h123456, 24'h123456, LOP_XOR, 1'b0);
    step();
    drive_op(24'h123456, 24'h123456, LOP_XOR, 1'b1);
    step();
    check("zero_y", 32'(bus.out_y), 32'h000000);
`ifdef LOGIC_ZERO_FLAG_EN
    check("zero_flag_set", {31'd0, bus.out_zero}, 32'd1);
`endif
    idle();
    step();
    check("ones_y", 32'(bus.out_y), 32'hFFFFFF);
`ifdef LOGIC_ZERO_FLAG_EN
    check("zero_flag_clr", {31'd0, bus.out_zero}, 32'd0);
`endif
    wait_drain("drain_zero");

    // Reset asserted mid-operation: result in s2 must vanish at once
    bus.out_ready = 1'b0;
    drive_op(24'h0F0F0F, 24'hFFFFFF, LOP_AND, 1'b0);
    step();
    idle();
    step();
    check("midrst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_y", 32'(bus.out_y), 32'h000000);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("midrst_no_ghost", {31'd0, bus.out_valid}, 32'd0);

    // Short random burst with random backpressure
    for (int i = 0; i < 40; i++) begin
      drive_op(24'($urandom_range(0, 24'hFFFFFF)), 24'($urandom_range(0, 24'hFFFFFF)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    wait_drain("drain_random");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
